// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands CHUNK bits per clock with a registered inter-chunk carry.
// Optional SUBTRACT_EN adds a sub port selecting a + ~b + 1.
//
// state | meaning
// IDLE  | waiting for start, busy=0
// RUN   | adding chunk idx (0..N-1), busy=1
module chunked_serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_reg, b_reg, b_in;
    logic             carry_reg, c_in;
    logic [IDX_W-1:0] idx;
    logic             accept, last;
    logic [CHUNK-1:0] a_slice, b_slice, s_slice;
    logic             c_slice, msb_cin;

    always_comb begin
`ifdef SUBTRACT_EN
        b_in = sub ? ~b : b;
        c_in = sub ? 1'b1 : carryin;
`else
        b_in = b;
        c_in = carryin;
`endif
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (idx == IDX_LAST) begin
                    last       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy    = (state == RUN);
    assign a_slice = a_reg[idx*CHUNK +: CHUNK];
    assign b_slice = b_reg[idx*CHUNK +: CHUNK];
    assign {c_slice, s_slice} = {1'b0, a_slice} + {1'b0, b_slice} + (CHUNK + 1)'(carry_reg);
    // A sum bit is a ^ b ^ cin, so the carry into the MSB falls out of the MSB sum bit.
    assign msb_cin = s_slice[CHUNK-1] ^ a_slice[CHUNK-1] ^ b_slice[CHUNK-1];

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b_in;
                carry_reg <= c_in;
                idx       <= '0;
            end else if (busy) begin
                sum[idx*CHUNK +: CHUNK] <= s_slice;
                carry_reg               <= c_slice;
                idx                     <= idx + 1'b1;
                if (last) begin
                    carryout <= c_slice;
                    overflow <= msb_cin ^ c_slice;
                    idx      <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder at WIDTH=8 (CHUNK=4, or CHUNK=2 with SUBTRACT_EN):
// fixed vectors, random adds against an arithmetic model, and handshake corner sequences.
module tb_chunked_serial_adder;
    localparam int WIDTH = 8;
`ifdef SUBTRACT_EN
    localparam int CHUNK = 2;
`else
    localparam int CHUNK = 4;
`endif
    localparam int N = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             reset_n, start, carryin;
    logic [WIDTH-1:0] a, b;
`ifdef SUBTRACT_EN
    logic             sub;
`endif
    logic             busy, done, carryout, overflow;
    logic [WIDTH-1:0] sum;

    int errors = 0;
    int checks = 0;

    chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .carryin(carryin),
`ifdef SUBTRACT_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .carryout(carryout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va, vb;
        logic       vc, vs;
        logic [7:0] esum;
        logic       eco, eov;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {overflow, carryout, sum} from plain integer arithmetic
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic c, input logic s);
        logic [7:0] ye;
        logic [8:0] t;
        logic       ov;
        ye = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, ye} + 9'(s ? 1'b1 : c);
        ov = (x[7] == ye[7]) && (t[7] != x[7]);
        return {ov, t};
    endfunction

    task automatic do_add(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                          output logic [7:0] rs, output logic rc, output logic ro,
                          output int lat, output int bcnt);
        a = ta; b = tb2; carryin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        rs = sum; rc = carryout; ro = overflow;
    endtask

    initial begin
        logic [7:0] rs, ra, rb;
        logic       rc, ro, rcin, rsub;
        logic [9:0] m;
        int         lat, bcnt, seen;

        vecs.push_back('{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
`ifdef SUBTRACT_EN
        vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
        sub = 1'b0;
`endif

        reset_n = 1'b0; start = 1'b0; a = '0; b = '0; carryin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_sum", 32'(sum), 0);
        check("reset_carryout", 32'(carryout), 0);
        check("reset_overflow", 32'(overflow), 0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
`ifdef SUBTRACT_EN
            sub = vecs[i].vs;
`endif
            do_add(vecs[i].va, vecs[i].vb, vecs[i].vc, rs, rc, ro, lat, bcnt);
            check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].esum));
            check($sformatf("vec%0d_carryout", i), 32'(rc), 32'(vecs[i].eco));
            check($sformatf("vec%0d_overflow", i), 32'(ro), 32'(vecs[i].eov));
            check($sformatf("vec%0d_latency", i), lat, N);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, N);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
        end

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom);
            rsub = 1'b0;
`ifdef SUBTRACT_EN
            rsub = 1'($urandom);
            sub  = rsub;
`endif
            m = model(ra, rb, rcin, rsub);
            do_add(ra, rb, rcin, rs, rc, ro, lat, bcnt);
            check("rand_sum", 32'(rs), 32'(m[7:0]));
            check("rand_carryout", 32'(rc), 32'(m[8]));
            check("rand_overflow", 32'(ro), 32'(m[9]));
            check("rand_latency", lat, N);
        end

`ifdef SUBTRACT_EN
        sub = 1'b0;
`endif
        // start held through RUN is ignored; still high in the done cycle it is accepted
        a = 8'h3C; b = 8'h05; carryin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'h11; b = 8'h22;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ignore_latency", lat, N);
        check("ignore_sum", 32'(sum), 32'h41);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        check("b2b_done_low", 32'(done), 0);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_latency", lat, N);
        check("b2b_sum", 32'(sum), 32'h33);
        check("b2b_carryout", 32'(carryout), 0);

        // reset one cycle after accept aborts the add
        a = 8'hFF; b = 8'h01; carryin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_sum", 32'(sum), 0);
        reset_n = 1'b1;
        seen = 0;
        repeat (N + 3) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        check("abort_no_done", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
